// File: rtl/popcount_frame_accumulator.sv
// -----------------------------------------------------------------------------
// popcount_frame_accumulator
//
// Accumulates a stream of per-word popcounts into frames of FRAME_LEN valid
// samples. Each closed frame produces its total, its peak sample, its sample
// count and a threshold flag. A frame can also be closed early with a flush.
// Results drive link-quality and statistics logic downstream.
//
// Ports
//   clk_i       in   1      clock, rising edge
//   srst_i      in   1      synchronous reset, active-high
//   data_i      in   CNT_W  popcount sample (valid range 0..WIDTH)
//   data_val_i  in   1      data_i valid this cycle
//   flush_i     in   1      close the current frame early
//   thresh_i    in   SUM_W  threshold for above_o, sampled at frame close
//   sum_o       out  SUM_W  total of the last closed frame
//   max_o       out  CNT_W  largest sample of the last closed frame
//   len_o       out  IDX_W  number of samples in the last closed frame
//   above_o     out  1      sum_o >= thresh_i as sampled at close
//   data_val_o  out  1      one-cycle pulse when the result outputs update
//   err_o       out  1      sticky: a sample above WIDTH was received
// -----------------------------------------------------------------------------
module popcount_frame_accumulator #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 8,
  localparam int CNT_W    = $clog2(WIDTH) + 1,
  localparam int SUM_W    = $clog2(WIDTH * FRAME_LEN + 1),
  localparam int IDX_W    = $clog2(FRAME_LEN) + 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             data_val_i,
  input  logic             flush_i,
  input  logic [SUM_W-1:0] thresh_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] max_o,
  output logic [IDX_W-1:0] len_o,
  output logic             above_o,
  output logic             data_val_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  // Out-of-range popcounts are pinned to the largest legal count.
  function automatic logic [CNT_W-1:0] clamp_sample(input logic [CNT_W-1:0] s);
    return (s > CNT_MAX) ? CNT_MAX : s;
  endfunction

  function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Frame state
  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_run_max;
  logic [IDX_W-1:0] r_idx;

  // Result registers
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_max;
  logic [IDX_W-1:0] r_len;
  logic             r_above;
  logic             r_vld;
  logic             r_err;

  logic [CNT_W-1:0] w_sample;
  logic             w_oor;
  logic             w_filling;
  logic             w_close;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_max;
  logic [IDX_W-1:0] w_len;

  always_comb begin
    w_sample  = '0;
    w_oor     = 1'b0;
    if (data_val_i) begin
      w_sample = clamp_sample(data_i);
      w_oor    = (data_i > CNT_MAX);
    end
    // Every accepted sample advances idx, so a nonzero idx means FILLING.
    w_filling = (r_idx != '0);
    // A flush that coincides with the last sample folds into one close.
    w_close   = (data_val_i && (r_idx == IDX_LAST)) ||
                (flush_i && (w_filling || data_val_i));
    w_sum     = r_acc + SUM_W'(w_sample);
    w_max     = max_cnt(r_run_max, w_sample);
    w_len     = r_idx + IDX_W'(data_val_i);
  end

  // Frame accumulation and result capture
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_acc     <= '0;
      r_run_max <= '0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_max     <= '0;
      r_len     <= '0;
      r_above   <= 1'b0;
      r_vld     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_vld <= w_close;
      if (w_oor) begin
        r_err <= 1'b1;
      end
      if (w_close) begin
        r_sum     <= w_sum;
        r_max     <= w_max;
        r_len     <= w_len;
        r_above   <= (w_sum >= thresh_i);
        r_acc     <= '0;
        r_run_max <= '0;
        r_idx     <= '0;
      end else if (data_val_i) begin
        r_acc     <= w_sum;
        r_run_max <= w_max;
        r_idx     <= w_len;
      end
    end
  end

  assign sum_o      = r_sum;
  assign max_o      = r_max;
  assign len_o      = r_len;
  assign above_o    = r_above;
  assign data_val_o = r_vld;
  assign err_o      = r_err;

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
module tb_popcount_frame_accumulator;

  localparam int WIDTH     = 16;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = $clog2(WIDTH) + 1;
  localparam int SUM_W     = $clog2(WIDTH * FRAME_LEN + 1);
  localparam int IDX_W     = $clog2(FRAME_LEN) + 1;

  logic             clk = 1'b0;
  logic             srst_i;
  logic [CNT_W-1:0] data_i;
  logic             data_val_i;
  logic             flush_i;
  logic [SUM_W-1:0] thresh_i;
  logic [SUM_W-1:0] sum_o;
  logic [CNT_W-1:0] max_o;
  logic [IDX_W-1:0] len_o;
  logic             above_o;
  logic             data_val_o;
  logic             err_o;

  always #5 clk = ~clk;

  popcount_frame_accumulator #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .flush_i(flush_i), .thresh_i(thresh_i), .sum_o(sum_o), .max_o(max_o),
    .len_o(len_o), .above_o(above_o), .data_val_o(data_val_o), .err_o(err_o)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the open frame is a list of clamped samples; a close
  // reduces that list to its sum, peak and length.
  int exp_sum = 0, exp_max = 0, exp_len = 0;
  bit exp_above = 1'b0, exp_vld = 1'b0, exp_err = 1'b0;
  int frame_q[$];

  always @(posedge clk) begin : model
    int s, tot, pk;
    bit close;
    if (srst_i) begin
      exp_sum = 0; exp_max = 0; exp_len = 0;
      exp_above = 0; exp_vld = 0; exp_err = 0;
      frame_q.delete();
    end else begin
      exp_vld = 0;
      if (data_val_i) begin
        s = int'(data_i);
        if (s > WIDTH) begin
          s = WIDTH;
          exp_err = 1;
        end
        frame_q.push_back(s);
      end
      close = (data_val_i && frame_q.size() == FRAME_LEN) ||
              (flush_i && frame_q.size() > 0);
      if (close) begin
        tot = 0;
        pk  = 0;
        foreach (frame_q[i]) begin
          tot += frame_q[i];
          if (frame_q[i] > pk) pk = frame_q[i];
        end
        exp_sum   = tot;
        exp_max   = pk;
        exp_len   = frame_q.size();
        exp_above = (tot >= int'(thresh_i));
        exp_vld   = 1;
        frame_q.delete();
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_val_o", data_val_o, exp_vld);
      chk("sum_o",      sum_o,      exp_sum);
      chk("max_o",      max_o,      exp_max);
      chk("len_o",      len_o,      exp_len);
      chk("above_o",    above_o,    exp_above);
      chk("err_o",      err_o,      exp_err);
    end
  end

  // Drive one cycle of inputs; returns just after the edge that samples them.
  task automatic cyc(input bit v, input int d, input bit f, input bit r);
    data_val_i = v;
    data_i     = CNT_W'(d);
    flush_i    = f;
    srst_i     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input bit v, input int s, input int m,
                     input int l, input bit a);
    chk({name, ".vld"},   data_val_o, v);
    chk({name, ".sum"},   sum_o,      s);
    chk({name, ".max"},   max_o,      m);
    chk({name, ".len"},   len_o,      l);
    chk({name, ".above"}, above_o,    a);
  endtask

  initial begin
    srst_i = 1'b1; data_i = '0; data_val_i = 1'b0; flush_i = 1'b0;
    thresh_i = SUM_W'(20);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    cyc(1, 9, 1, 1);
    lit("reset", 0, 0, 0, 0, 0);
    chk("reset.err", err_o, 0);

    // Full frame
    cyc(1, 3, 0, 0); cyc(1, 5, 0, 0); cyc(1, 16, 0, 0); cyc(1, 0, 0, 0);
    lit("full", 1, 24, 16, 4, 1);
    cyc(0, 0, 0, 0);
    lit("full_hold", 0, 24, 16, 4, 1);

    // Gapped frame (idle data ignored), then back-to-back frame
    cyc(1, 1, 0, 0); cyc(0, 31, 0, 0); cyc(1, 1, 0, 0); cyc(0, 7, 0, 0);
    cyc(1, 1, 0, 0); cyc(0, 0, 0, 0); cyc(1, 1, 0, 0);
    lit("gap", 1, 4, 1, 4, 0);
    cyc(1, 2, 0, 0);
    lit("gap_hold", 0, 4, 1, 4, 0);
    cyc(1, 2, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0);
    lit("b2b", 1, 8, 2, 4, 0);

    // Flush alone, flush with sample, flush while empty
    cyc(1, 7, 0, 0); cyc(1, 9, 0, 0); cyc(0, 0, 1, 0);
    lit("flush", 1, 16, 9, 2, 0);
    cyc(1, 2, 0, 0); cyc(1, 4, 1, 0);
    lit("flush_dv", 1, 6, 4, 2, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 1, 0);
    lit("flush_empty", 0, 6, 4, 2, 0);

    // Flush on the last sample: one close, next frame clean
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 1, 0);
    lit("flush_last", 1, 10, 4, 4, 0);
    cyc(0, 0, 0, 0);
    chk("flush_last.single", data_val_o, 0);
    cyc(1, 5, 0, 0); cyc(1, 5, 0, 0); cyc(1, 5, 0, 0); cyc(1, 5, 0, 0);
    lit("thresh_equal", 1, 20, 5, 4, 1);

    // Clamp and sticky error
    cyc(1, 20, 0, 0);
    chk("clamp.err_early", err_o, 1);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    lit("clamp", 1, 16, 16, 4, 0);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("clamp.err_sticky", err_o, 1);

    // Reset mid-frame
    cyc(1, 5, 0, 0); cyc(1, 5, 0, 0); cyc(0, 0, 0, 1);
    lit("rst_mid", 0, 0, 0, 0, 0);
    chk("rst_mid.err", err_o, 0);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("rst_mid.no_pulse", data_val_o, 0);
    cyc(1, 1, 0, 0);
    lit("after_rst", 1, 4, 1, 4, 0);

    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/popcount_frame_accumulator.md
Name: popcount_frame_accumulator

Overview:
Downstream consumer of the bit population counter. Takes the per-word popcount stream (count plus valid) and accumulates it over frames of FRAME_LEN valid samples. At the end of each frame it emits the frame total, the per-frame peak count, and a threshold-comparison flag. Frames can also be closed early with a flush. Results feed the link-quality and statistics logic.

Parameters:
WIDTH, 16, word width of the upstream counter; input counts range 0..WIDTH
FRAME_LEN, 8, valid samples per frame; must be >= 2
CNT_W, $clog2(WIDTH)+1, derived (localparam); input count width
SUM_W, $clog2(WIDTH*FRAME_LEN+1), derived (localparam); frame-sum width
IDX_W, $clog2(FRAME_LEN)+1, derived (localparam); sample-index width

Ports:
clk_i  in  1  clock; all logic on the rising edge
srst_i  in  1  synchronous reset, active-high
data_i  in  CNT_W  popcount sample from the upstream counter
data_val_i  in  1  data_i is valid this cycle
flush_i  in  1  close the current frame early
thresh_i  in  SUM_W  threshold for above_o; sampled at frame close
sum_o  out  SUM_W  total of the last closed frame
max_o  out  CNT_W  largest sample in the last closed frame
len_o  out  IDX_W  number of samples in the last closed frame
above_o  out  1  sum_o >= thresh_i as sampled at close
data_val_o  out  1  one-cycle pulse: result outputs updated
err_o  out  1  sticky: a sample with data_i > WIDTH was received

Behaviour:
- Reset: while srst_i is high, all outputs and internal state clear to 0 (sum_o, max_o, len_o, above_o, data_val_o, err_o, accumulator, running max, sample index). srst_i overrides all other inputs.
- Internal state: acc (SUM_W bits), run_max (CNT_W bits), idx (IDX_W bits, 0..FRAME_LEN-1). Frame states:
  - EMPTY when idx == 0 and no samples have been accumulated.
  - FILLING otherwise.
- Sample clamp: when data_val_i=1 and data_i > WIDTH, the sample is clamped to WIDTH and err_o is set to 1. err_o stays set until reset.
- Accept: data_val_i=1 without a close → acc += sample, run_max = max(run_max, sample), idx++.
- Close conditions (evaluated in the same cycle as the last sample):
  - (a) data_val_i=1 and idx == FRAME_LEN-1;
  - (b) flush_i=1 while FILLING, or flush_i=1 together with data_val_i=1.
- Close action, applied on the next clock edge:
  - sum_o = acc + sample (sample = 0 if data_val_i=0);
  - max_o = max(run_max, sample);
  - len_o = idx + data_val_i;
  - above_o = (new sum_o >= thresh_i);
  - data_val_o = 1;
  - acc, run_max and idx clear to 0.
- Latency: data_val_o is asserted exactly 1 cycle after the closing input cycle. No backpressure; the block accepts a sample every cycle, and back-to-back frames need no idle cycles.
- Flush while EMPTY with data_val_i=0: no effect, no pulse.
- data_val_o is high for exactly one cycle per close. sum_o, max_o, len_o and above_o hold their values until the next close.
- Width rule: SUM_W holds WIDTH*FRAME_LEN, so the accumulator cannot wrap.
- flush_i and data_val_i in the same cycle with idx == FRAME_LEN-1: a single close with len_o = FRAME_LEN (not two closes).
- Reset asserted mid-frame: the partial frame is discarded and no output pulse is generated.
- data_i is ignored whenever data_val_i=0.

Test Plan:
Common setup: WIDTH=16, FRAME_LEN=4, thresh_i=20.
- Full frame: samples 3,5,16,0 on 4 consecutive cycles → 1 cycle after the 4th sample: data_val_o=1, sum_o=24, max_o=16, len_o=4, above_o=1; data_val_o=0 on the next cycle.
- Gapped input plus back-to-back frames: samples 1,1,1,1 with idle cycles between them, then 2,2,2,2 on consecutive cycles → two pulses: (sum_o=4, above_o=0) then (sum_o=8); first-frame outputs held between the pulses.
- Flush: samples 7,9, then flush_i alone → sum_o=16, max_o=9, len_o=2. Flush with data_val_i=1, data_i=4 after one sample of 2 → sum_o=6, len_o=2. Flush while EMPTY → no pulse.
- Flush on the last sample: samples 1,2,3, then data_i=4 with flush_i=1 → exactly one pulse, sum_o=10, len_o=4; the next frame starts clean.
- Clamp: data_i=20 inside a frame of 20,0,0,0 → sum_o=16, max_o=16, err_o=1 and remains 1 across later frames until srst_i.
- Reset mid-frame: samples 5,5, then srst_i for 1 cycle, then 1,1,1,1 → no pulse for the partial frame; next pulse sum_o=4, len_o=4; all outputs read 0 during reset.
